// File: rtl/life_gen_ctrl_pkg.sv
// Shared types and grid geometry for the Game of Life generation controller.
package life_pkg;

    localparam int GRID_W = 64;
    localparam int ROW_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } life_state_t;

endpackage

// File: rtl/life_gen_ctrl_if.sv
// Command/status bundle between the generation controller and its host/datapath.
interface life_gen_ctrl_if
    import life_pkg::*;
#(
    parameter int GEN_W = 16
);
    logic              load;
    logic [GRID_W-1:0] seed;
    logic              run;
    logic              step;
    logic              stop;
    logic [GRID_W-1:0] grid_evolve;
    logic [GRID_W-1:0] grid;
    logic [GEN_W-1:0]  gen_count;
    logic              running;
    logic              done;
    logic              stable;
    logic              extinct;
    logic              osc2;

    modport master (
        output load, seed, run, step, stop, grid_evolve,
        input  grid, gen_count, running, done, stable, extinct, osc2
    );

    modport slave (
        input  load, seed, run, step, stop, grid_evolve,
        output grid, gen_count, running, done, stable, extinct, osc2
    );
endinterface

// File: rtl/life_gen_ctrl_tick_div.sv
// Generation-rate divider: counts 0..TICK_DIV-1 and flags the terminal count.
module life_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/life_gen_ctrl.sv
// Generation controller: owns the grid register, commits evolve results, auto-halts.
// Optional period-2 oscillator detection is built when LIFE_OSC2_DETECT_EN is defined.
//
// state | meaning
// IDLE  | holding; step commits one generation, run starts free-running
// RUN   | committing one generation every TICK_DIV cycles
// HALT  | still life / extinction / limit / oscillator reached; only load exits
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int GEN_W    = 16,
    parameter int MAX_GEN  = 1000,
    parameter int TICK_DIV = 4
) (
    input logic             clk,
    input logic             reset,
    life_gen_ctrl_if.slave  bus
);
    life_state_t       state, state_nxt;
    logic [GRID_W-1:0] grid_q;
    logic [GEN_W-1:0]  gen_q, gen_nxt;
    logic              stable_q, extinct_q, osc2_q;
    logic              tick, tick_en, tick_clr, commit, halt_hit, osc2_hit;

    life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    assign gen_nxt = (&gen_q) ? gen_q : gen_q + GEN_W'(1);

`ifdef LIFE_OSC2_DETECT_EN
    logic [GRID_W-1:0] prev_grid;
    logic              prev_valid;

    assign osc2_hit = prev_valid && (bus.grid_evolve == prev_grid)
                      && (bus.grid_evolve != grid_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_grid  <= '0;
            prev_valid <= 1'b0;
            osc2_q     <= 1'b0;
        end else if (bus.load) begin
            prev_grid  <= '0;
            prev_valid <= 1'b0;
            osc2_q     <= 1'b0;
        end else if (commit) begin
            prev_grid  <= grid_q;
            prev_valid <= 1'b1;
            osc2_q     <= osc2_q | osc2_hit;
        end
    end
`else
    assign osc2_hit = 1'b0;
    assign osc2_q   = 1'b0;
`endif

    assign halt_hit = (bus.grid_evolve == grid_q) || (bus.grid_evolve == '0)
                      || (gen_nxt == GEN_W'(MAX_GEN)) || osc2_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority load > stop > run > step; the tick counter only advances in RUN.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        tick_en   = 1'b0;
        tick_clr  = 1'b1;
        if (bus.load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.stop && bus.run) begin
                        state_nxt = RUN;
                    end else if (!bus.stop && bus.step) begin
                        commit = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else begin
                        tick_clr = 1'b0;
                        tick_en  = 1'b1;
                        if (tick) begin
                            commit = 1'b1;
                            if (halt_hit) state_nxt = HALT;
                        end
                    end
                end
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_q    <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else if (bus.load) begin
            grid_q    <= bus.seed;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else if (commit) begin
            grid_q    <= bus.grid_evolve;
            gen_q     <= gen_nxt;
            stable_q  <= (bus.grid_evolve == grid_q);
            extinct_q <= (bus.grid_evolve == '0);
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.running   = (state == RUN);
    assign bus.done      = (state == HALT);
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
    assign bus.osc2      = osc2_q;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl (MAX_GEN=10, TICK_DIV=4) with a behavioural evolve datapath.
module tb_life_gen_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    life_gen_ctrl_if #(.GEN_W(16)) bus ();

    life_gen_ctrl #(.GEN_W(16), .MAX_GEN(10), .TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [63:0] BLOCK  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] BLINKH = 64'h0000_0000_3800_0000;
    localparam logic [63:0] BLINKV = 64'h0000_0010_1010_0000;
    localparam logic [63:0] CORNER = 64'h8100_0000_0000_0081;
    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;

    // Bounded 8x8 Life: cells outside the board are dead.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8
                            && (c + dc) >= 0 && (c + dc) < 8) begin
                            if (g[(r + dr) * 8 + (c + dc)]) cnt++;
                        end
                    end
                end
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    assign bus.grid_evolve = life_next(bus.grid);

    // {grid, gen_count, running, done, stable, extinct, osc2}
    function automatic logic [84:0] snap();
        return {bus.grid, bus.gen_count, bus.running, bus.done, bus.stable, bus.extinct, bus.osc2};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic s, input logic p,
                         input logic [63:0] sd);
        bus.load = l;
        bus.run  = r;
        bus.step = s;
        bus.stop = p;
        bus.seed = sd;
        cycles(1);
        bus.load = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [84:0] obs;
        reset = 1'b1;
        cycles(2);
        obs = snap();
        vectors++;
        if (obs !== 85'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs, 85'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        cycles(2);
        obs = snap();
        vectors++;
        if (obs !== 85'd0) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs, 85'd0);
        end
    endtask

    task automatic test_block_still();
        logic [84:0] obs;
        drive(1, 0, 0, 0, BLOCK);
        drive(0, 1, 0, 0, '0);
        obs = snap();
        vectors++;
        if (obs !== {BLOCK, 16'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL block_enter_run: got %h expected %h", obs, {BLOCK, 16'd0, 5'b10000});
        end
        cycles(3);
        obs = snap();
        vectors++;
        if (obs !== {BLOCK, 16'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL block_before_tick: got %h expected %h", obs, {BLOCK, 16'd0, 5'b10000});
        end
        cycles(1);
        obs = snap();
        vectors++;
        if (obs !== {BLOCK, 16'd1, 5'b01100}) begin
            miscompares++;
            $display("FAIL block_halt: got %h expected %h", obs, {BLOCK, 16'd1, 5'b01100});
        end
        drive(0, 1, 1, 1, '0);
        cycles(5);
        obs = snap();
        vectors++;
        if (obs !== {BLOCK, 16'd1, 5'b01100}) begin
            miscompares++;
            $display("FAIL halt_ignores_cmds: got %h expected %h", obs, {BLOCK, 16'd1, 5'b01100});
        end
    endtask

    task automatic test_single_step();
        logic [84:0] obs;
        drive(1, 0, 0, 0, 64'h1);
        obs = snap();
        vectors++;
        if (obs !== {64'h1, 16'd0, 5'b00000}) begin
            miscompares++;
            $display("FAIL load_from_halt: got %h expected %h", obs, {64'h1, 16'd0, 5'b00000});
        end
        drive(0, 0, 1, 0, '0);
        obs = snap();
        vectors++;
        if (obs !== {64'h0, 16'd1, 5'b00010}) begin
            miscompares++;
            $display("FAIL step_extinct: got %h expected %h", obs, {64'h0, 16'd1, 5'b00010});
        end
        drive(0, 0, 1, 0, '0);
        obs = snap();
        vectors++;
        if (obs !== {64'h0, 16'd2, 5'b00110}) begin
            miscompares++;
            $display("FAIL step_both_flags: got %h expected %h", obs, {64'h0, 16'd2, 5'b00110});
        end
    endtask

    task automatic test_blinker();
        logic [84:0] obs;
        drive(1, 0, 0, 0, BLINKH);
        drive(0, 1, 0, 0, '0);
        cycles(4);
        obs = snap();
        vectors++;
        if (obs !== {BLINKV, 16'd1, 5'b10000}) begin
            miscompares++;
            $display("FAIL blinker_gen1: got %h expected %h", obs, {BLINKV, 16'd1, 5'b10000});
        end
        cycles(4);
        obs = snap();
`ifdef LIFE_OSC2_DETECT_EN
        vectors++;
        if (obs !== {BLINKH, 16'd2, 5'b01001}) begin
            miscompares++;
            $display("FAIL blinker_osc2_halt: got %h expected %h", obs, {BLINKH, 16'd2, 5'b01001});
        end
`else
        vectors++;
        if (obs !== {BLINKH, 16'd2, 5'b10000}) begin
            miscompares++;
            $display("FAIL blinker_gen2: got %h expected %h", obs, {BLINKH, 16'd2, 5'b10000});
        end
        cycles(28);
        obs = snap();
        vectors++;
        if (obs !== {BLINKV, 16'd9, 5'b10000}) begin
            miscompares++;
            $display("FAIL blinker_gen9: got %h expected %h", obs, {BLINKV, 16'd9, 5'b10000});
        end
        cycles(4);
        obs = snap();
        vectors++;
        if (obs !== {BLINKH, 16'd10, 5'b01000}) begin
            miscompares++;
            $display("FAIL blinker_max_gen: got %h expected %h", obs, {BLINKH, 16'd10, 5'b01000});
        end
`endif
    endtask

    task automatic test_priority();
        logic [84:0] obs;
        drive(1, 0, 0, 0, BLINKH);
        drive(0, 1, 0, 0, '0);
        cycles(5);
        obs = snap();
        vectors++;
        if (obs !== {BLINKV, 16'd1, 5'b10000}) begin
            miscompares++;
            $display("FAIL prio_mid_run: got %h expected %h", obs, {BLINKV, 16'd1, 5'b10000});
        end
        drive(1, 1, 0, 0, CORNER);
        obs = snap();
        vectors++;
        if (obs !== {CORNER, 16'd0, 5'b00000}) begin
            miscompares++;
            $display("FAIL prio_load_over_run: got %h expected %h", obs, {CORNER, 16'd0, 5'b00000});
        end
        drive(0, 0, 1, 1, '0);
        cycles(2);
        obs = snap();
        vectors++;
        if (obs !== {CORNER, 16'd0, 5'b00000}) begin
            miscompares++;
            $display("FAIL prio_stop_over_step: got %h expected %h", obs, {CORNER, 16'd0, 5'b00000});
        end
    endtask

    task automatic test_stop_resume();
        logic [84:0] obs;
        drive(0, 1, 0, 0, '0);
        drive(0, 0, 1, 0, '0);
        cycles(1);
        drive(0, 0, 0, 1, '0);
        obs = snap();
        vectors++;
        if (obs !== {CORNER, 16'd0, 5'b00000}) begin
            miscompares++;
            $display("FAIL stop_no_commit: got %h expected %h", obs, {CORNER, 16'd0, 5'b00000});
        end
        cycles(4);
        obs = snap();
        vectors++;
        if (obs !== {CORNER, 16'd0, 5'b00000}) begin
            miscompares++;
            $display("FAIL stop_stays_idle: got %h expected %h", obs, {CORNER, 16'd0, 5'b00000});
        end
        drive(0, 1, 0, 0, '0);
        cycles(3);
        obs = snap();
        vectors++;
        if (obs !== {CORNER, 16'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL resume_tick_cleared: got %h expected %h", obs, {CORNER, 16'd0, 5'b10000});
        end
        cycles(1);
        obs = snap();
        vectors++;
        if (obs !== {64'h0, 16'd1, 5'b01010}) begin
            miscompares++;
            $display("FAIL resume_extinct_halt: got %h expected %h", obs, {64'h0, 16'd1, 5'b01010});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [84:0] obs;
        logic [63:0] g3;
        g3 = life_next(life_next(life_next(GLIDER)));
        drive(1, 0, 0, 0, GLIDER);
        drive(0, 1, 0, 0, '0);
        cycles(12);
        obs = snap();
        vectors++;
        if (obs !== {g3, 16'd3, 5'b10000}) begin
            miscompares++;
            $display("FAIL glider_gen3: got %h expected %h", obs, {g3, 16'd3, 5'b10000});
        end
        #2;
        reset = 1'b1;
        #1;
        obs = snap();
        vectors++;
        if (obs !== 85'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, 85'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        cycles(1);
        drive(0, 1, 0, 0, '0);
        cycles(3);
        obs = snap();
        vectors++;
        if (obs !== {64'h0, 16'd0, 5'b10000}) begin
            miscompares++;
            $display("FAIL post_reset_run: got %h expected %h", obs, {64'h0, 16'd0, 5'b10000});
        end
        cycles(1);
        obs = snap();
        vectors++;
        if (obs !== {64'h0, 16'd1, 5'b01110}) begin
            miscompares++;
            $display("FAIL post_reset_extinct: got %h expected %h", obs, {64'h0, 16'd1, 5'b01110});
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        bus.stop = 1'b0;
        bus.seed = '0;
        test_reset();
        test_block_still();
        test_single_step();
        test_blinker();
        test_priority();
        test_stop_resume();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Generation controller for the 8x8 Game of Life engine; sits directly around the combinational evolve datapath.
- Owns the 64-bit grid state register.
  - Drives `grid` into the datapath.
  - Commits the datapath's `grid_evolve` back into the register on single-step or free-running ticks.
- Counts generations and halts automatically on still life, extinction or the generation limit.
- Cell index = row*8 + col throughout.

Parameters:
- GEN_W, 16: width of generation counter.
- MAX_GEN, 1000: generation limit. Reaching it in RUN forces HALT. Must be < 2**GEN_W.
- TICK_DIV, 4: clock cycles per generation in RUN. Must be >= 1; TICK_DIV=1 gives one generation per cycle.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- load  in  1  pulse: grid <= seed, clear counters/flags
- seed  in  64  initial pattern
- run  in  1  pulse: start free-running
- step  in  1  pulse: advance one generation (IDLE only)
- stop  in  1  pulse: RUN -> IDLE
- grid_evolve  in  64  next generation from evolve datapath (combinational function of grid)
- grid  out  64  current generation, to datapath and display
- gen_count  out  GEN_W  generations committed since last load
- running  out  1  state == RUN
- done  out  1  state == HALT
- stable  out  1  last commit had grid_evolve == grid
- extinct  out  1  last commit produced all-zero grid
- osc2  out  1  period-2 oscillator detected (see Optional Feature)

Behaviour:
- Reset: reset asynchronous, active-high; clock clk.
  - All of the following are 0 in reset: grid, gen_count, running, done, stable, extinct, osc2, tick counter.
  - State = IDLE.
- Input priority each cycle: load > stop > run > step. Lower-priority pulses arriving in the same cycle are dropped.
- States: IDLE, RUN, HALT (encoded 2 bits).
- load, in any state:
  - Next cycle: grid = seed, gen_count = 0, all flags = 0, tick counter = 0.
  - Next state = IDLE. Applies mid-RUN and in HALT.
- "Commit" is defined as:
  - grid <= grid_evolve.
  - gen_count <= gen_count+1, saturating at all-ones.
  - stable <= (grid_evolve == grid).
  - extinct <= (grid_evolve == 0).
  - Both flags may be set together, e.g. when grid is already 0.
- IDLE:
  - step -> one commit visible on the next edge; state stays IDLE; flags update but never force HALT.
  - run -> RUN, tick counter = 0.
  - stop is ignored.
- RUN:
  - Tick counter counts 0..TICK_DIV-1. A commit happens on the cycle the counter is at TICK_DIV-1; the counter then wraps to 0.
  - First commit occurs TICK_DIV cycles after entering RUN.
  - A commit transitions to HALT when any of the following hold:
    - grid_evolve == grid
    - grid_evolve == 0
    - new gen_count == MAX_GEN
    - osc2 condition (if the feature is enabled)
  - Otherwise stay in RUN.
  - stop -> IDLE with no commit that cycle; tick counter cleared.
  - step and run are ignored in RUN.
- HALT:
  - grid and gen_count are held; done=1.
  - run, step and stop are ignored; only load exits.
- Latency: outputs are registered; a commit is visible 1 cycle after its triggering edge. No combinational path from inputs to outputs.
- Reset asserted mid-RUN returns everything to reset values immediately. Any in-flight generation is discarded.

Optional Feature:
- Macro: LIFE_OSC2_DETECT_EN.
- With the macro defined:
  - Adds a 64-bit prev_grid register; on every commit, prev_grid <= grid (pre-commit value).
  - Cleared by load and reset.
  - Tracks a valid bit, set after the first commit since load.
  - On a commit with valid=1 and grid_evolve == prev_grid and grid_evolve != grid: osc2 <= 1.
  - In RUN this forces HALT; in IDLE-step it only sets the flag.
  - osc2 is cleared by load.
- Without the macro: no prev_grid register, and osc2 is constant 0.

Decomposition:
- Package life_pkg:
  - GRID_W=64, ROW_W=8.
  - typedef enum logic [1:0] {IDLE, RUN, HALT} life_state_t.
- Sub-module life_tick_div:
  - Parameter TICK_DIV; inputs clk, reset, clr, en; output tick.
  - Modulo counter asserting tick at terminal count.
- The evolve datapath is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Block still life: load seed with bits 27,28,35,36 set, then run with TICK_DIV=4 -> first commit 4 cycles after run; grid unchanged, gen_count=1, stable=1, done=1.
- Single cell: load bit 0 only, then step -> grid=0, extinct=1, gen_count=1, state remains IDLE (running=0, done=0).
- Blinker, macro defined: load bits 27,28,29, then run.
  - Gen 1: grid = bits 20,28,36.
  - Gen 2: osc2=1, done=1, gen_count=2.
- Blinker, macro undefined, MAX_GEN=10: same stimulus -> oscillates; done=1 at gen_count=10 with grid = bits 27,28,29, stable=0, osc2=0.
- Simultaneous pulses: load together with run mid-RUN -> grid=seed, gen_count=0, IDLE (run dropped); then step together with stop in IDLE -> stop ignored, step dropped by priority, no commit.
- Reset mid-RUN: assert reset at gen 3 -> all outputs 0 asynchronously. After release, run with no load -> grid 0 commits to extinct HALT at gen_count=1.
